// File: rtl/axi4lite_reg_slave.sv
`default_nettype none
// ============================================================================
// Module   : axi4lite_reg_slave
// Purpose  : AXI4-Lite slave with C_NUM_REGS 32-bit read/write registers.
//            Write and read channels run as independent FSMs. AW and W can
//            arrive in either order or in the same cycle, and byte strobes
//            are honoured. Register contents are exported flat on REG_OUT.
// Ports    : ACLK/ARESET        clock, synchronous active-high reset
//            AW*/W*/B*          write address, data and response channels
//            AR*/R*             read address and data channels
//            REG_OUT            register n at bits [32n+31:32n]
// Config   : AXI_SLVERR_EN - when defined, accesses to an index at or above
//            C_NUM_REGS respond with SLVERR. When undefined they respond
//            with OKAY. Both builds discard the write and return zero data.
// Revision : 1.0 - initial release
// ============================================================================
module axi4lite_reg_slave #(
  parameter int C_DATA_WIDTH = 32,
  parameter int C_ADDR_WIDTH = 6,
  parameter int C_NUM_REGS   = 4
) (
  input  logic                                ACLK,
  input  logic                                ARESET,
  input  logic [C_ADDR_WIDTH-1:0]             AWADDR,
  input  logic [2:0]                          AWPROT,
  input  logic                                AWVALID,
  output logic                                AWREADY,
  input  logic [C_DATA_WIDTH-1:0]             WDATA,
  input  logic [C_DATA_WIDTH/8-1:0]           WSTRB,
  input  logic                                WVALID,
  output logic                                WREADY,
  output logic [1:0]                          BRESP,
  output logic                                BVALID,
  input  logic                                BREADY,
  input  logic [C_ADDR_WIDTH-1:0]             ARADDR,
  input  logic [2:0]                          ARPROT,
  input  logic                                ARVALID,
  output logic                                ARREADY,
  output logic [C_DATA_WIDTH-1:0]             RDATA,
  output logic [1:0]                          RRESP,
  output logic                                RVALID,
  input  logic                                RREADY,
  output logic [C_DATA_WIDTH*C_NUM_REGS-1:0]  REG_OUT
);

  localparam int IDX_W  = C_ADDR_WIDTH - 2;
  localparam int STRB_W = C_DATA_WIDTH / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_WAIT = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  // write channel state
  logic [1:0]              w_state_q, w_state_d;
  logic                    aw_done_q, aw_done_d;
  logic [IDX_W-1:0]        aw_idx_q, aw_idx_d;
  logic                    w_done_q, w_done_d;
  logic [C_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]       wstrb_q, wstrb_d;
  logic                    bvalid_q, bvalid_d;
  logic [1:0]              bresp_q, bresp_d;

  // read channel state
  logic [0:0]              r_state_q, r_state_d;
  logic                    rvalid_q, rvalid_d;
  logic [1:0]              rresp_q, rresp_d;
  logic [C_DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [C_DATA_WIDTH-1:0] regs_q [C_NUM_REGS];
  logic [C_DATA_WIDTH-1:0] regs_d [C_NUM_REGS];

  logic                    aw_hs, w_hs, wr_fire, w_accepting;
  logic [IDX_W-1:0]        wr_idx, rd_idx;
  logic [C_DATA_WIDTH-1:0] wr_data, rd_word;
  logic [STRB_W-1:0]       wr_strb;
  logic                    wr_in_range, rd_in_range;
  logic                    unused_bits;

  // Ready is gated by ARESET so it reads low while reset is held and comes
  // up as soon as reset drops, since the FSM is already idle by then.
  assign w_accepting = (w_state_q != W_RESP) && !ARESET;
  assign AWREADY     = w_accepting && !aw_done_q;
  assign WREADY      = w_accepting && !w_done_q;
  assign ARREADY     = (r_state_q == R_IDLE) && !ARESET;

  assign aw_hs = AWVALID && AWREADY;
  assign w_hs  = WVALID && WREADY;

  // The half that arrives last is used straight off the bus, so the commit
  // happens on the edge that completes the pair.
  assign wr_idx  = aw_done_q ? aw_idx_q : AWADDR[C_ADDR_WIDTH-1:2];
  assign wr_data = w_done_q  ? wdata_q  : WDATA;
  assign wr_strb = w_done_q  ? wstrb_q  : WSTRB;
  assign wr_fire = (aw_done_q || aw_hs) && (w_done_q || w_hs);
  assign rd_idx  = ARADDR[C_ADDR_WIDTH-1:2];

  always_comb begin
    w_state_d   = w_state_q;
    aw_done_d   = aw_done_q;
    aw_idx_d    = aw_idx_q;
    w_done_d    = w_done_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    bvalid_d    = bvalid_q;
    bresp_d     = bresp_q;
    regs_d      = regs_q;
    wr_in_range = 1'b0;

    for (int n = 0; n < C_NUM_REGS; n++) begin
      if (wr_idx == IDX_W'(n)) wr_in_range = 1'b1;
    end

    if (aw_hs) begin
      aw_done_d = 1'b1;
      aw_idx_d  = AWADDR[C_ADDR_WIDTH-1:2];
    end
    if (w_hs) begin
      w_done_d = 1'b1;
      wdata_d  = WDATA;
      wstrb_d  = WSTRB;
    end

    case (w_state_q)
      W_IDLE, W_WAIT: begin
        if (wr_fire) begin
          // An out-of-range index matches no register, so nothing is written.
          for (int n = 0; n < C_NUM_REGS; n++) begin
            if (wr_idx == IDX_W'(n)) begin
              for (int b = 0; b < STRB_W; b++) begin
                if (wr_strb[b]) regs_d[n][8*b +: 8] = wr_data[8*b +: 8];
              end
            end
          end
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          bvalid_d  = 1'b1;
`ifdef AXI_SLVERR_EN
          bresp_d   = wr_in_range ? RESP_OKAY : RESP_SLVERR;
`else
          bresp_d   = RESP_OKAY;
`endif
          w_state_d = W_RESP;
        end else if (aw_done_d || w_done_d) begin
          w_state_d = W_WAIT;
        end
      end
      W_RESP: begin
        if (BREADY) begin
          bvalid_d  = 1'b0;
          bresp_d   = RESP_OKAY;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d   = r_state_q;
    rvalid_d    = rvalid_q;
    rresp_d     = rresp_q;
    rdata_d     = rdata_q;
    rd_word     = '0;
    rd_in_range = 1'b0;

    // Reads sample the pre-edge register values, so a same-cycle write to
    // the same register is not visible to this read.
    for (int n = 0; n < C_NUM_REGS; n++) begin
      if (rd_idx == IDX_W'(n)) begin
        rd_word     = regs_q[n];
        rd_in_range = 1'b1;
      end
    end

    case (r_state_q)
      R_IDLE: begin
        if (ARVALID && ARREADY) begin
          rdata_d   = rd_word;
`ifdef AXI_SLVERR_EN
          rresp_d   = rd_in_range ? RESP_OKAY : RESP_SLVERR;
`else
          rresp_d   = RESP_OKAY;
`endif
          rvalid_d  = 1'b1;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (RREADY) begin
          rvalid_d  = 1'b0;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state_q <= W_IDLE;
      aw_done_q <= 1'b0;
      aw_idx_q  <= '0;
      w_done_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      r_state_q <= R_IDLE;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      for (int n = 0; n < C_NUM_REGS; n++) regs_q[n] <= '0;
    end else begin
      w_state_q <= w_state_d;
      aw_done_q <= aw_done_d;
      aw_idx_q  <= aw_idx_d;
      w_done_q  <= w_done_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      r_state_q <= r_state_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      for (int n = 0; n < C_NUM_REGS; n++) regs_q[n] <= regs_d[n];
    end
  end

  assign BVALID = bvalid_q;
  assign BRESP  = bresp_q;
  assign RVALID = rvalid_q;
  assign RRESP  = rresp_q;
  assign RDATA  = rdata_q;

  for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_reg_out
    assign REG_OUT[C_DATA_WIDTH*g +: C_DATA_WIDTH] = regs_q[g];
  end

  // Protection bits and byte offsets carry no meaning for this slave.
`ifdef AXI_SLVERR_EN
  assign unused_bits = ^{AWPROT, ARPROT, AWADDR[1:0], ARADDR[1:0]};
`else
  assign unused_bits = ^{AWPROT, ARPROT, AWADDR[1:0], ARADDR[1:0],
                         wr_in_range, rd_in_range};
`endif

endmodule
`default_nettype wire

// File: doc/axi4lite_reg_slave.md
AXI4LITE_REG_SLAVE -- requirements
Module: axi4lite_reg_slave

Interface
REQ-001 SHALL have parameter C_DATA_WIDTH, default 32, meaning the data bus width; only 32 is supported.
REQ-002 SHALL have parameter C_ADDR_WIDTH, default 6, meaning the byte address width.
REQ-003 SHALL have parameter C_NUM_REGS, default 4, meaning the number of 32-bit registers implemented, from 1 to 2^(C_ADDR_WIDTH-2).
REQ-004 SHALL have the following ports, one per line as name, direction, width, meaning:
ACLK  in  1  single clock; all logic on the rising edge.
ARESET  in  1  reset, synchronous, active-high.
AWADDR  in  C_ADDR_WIDTH  write address.
AWPROT  in  3  write protection; ignored.
AWVALID  in  1  / AWREADY  out  1  write-address handshake.
WDATA  in  32  write data.
WSTRB  in  4  byte enables.
WVALID  in  1  / WREADY  out  1  write-data handshake.
BRESP  out  2  / BVALID  out  1  / BREADY  in  1  write response.
ARADDR  in  C_ADDR_WIDTH  read address.
ARPROT  in  3  read protection; ignored.
ARVALID  in  1  / ARREADY  out  1  read-address handshake.
RDATA  out  32  / RRESP  out  2  / RVALID  out  1  / RREADY  in  1  read data.
REG_OUT  out  32*C_NUM_REGS  flattened register contents; register n is at bits [32n+31:32n].

Function
REQ-005 SHALL decode the word index as addr[C_ADDR_WIDTH-1:2] and ignore addr[1:0].
REQ-006 SHALL implement the write path as an FSM with states W_IDLE, W_WAIT and W_RESP.
REQ-007 In W_IDLE and W_WAIT, SHALL hold AWREADY high until an address is latched and WREADY high until data and strobe are latched; AW and W SHALL be accepted in either order or in the same cycle.
REQ-008 SHALL move from W_IDLE to W_WAIT when only one of AW or W has been latched.
REQ-009 SHALL, in the cycle after both are latched, update each register byte whose WSTRB bit is 1, assert BVALID and enter W_RESP.
REQ-010 In W_RESP, SHALL hold AWREADY and WREADY low and hold BVALID and BRESP stable until BREADY is sampled high, then return to W_IDLE with BVALID low.
REQ-011 SHALL implement the read path as an FSM with states R_IDLE and R_DATA; ARREADY SHALL be high only in R_IDLE.
REQ-012 On an AR handshake, SHALL register RDATA and RRESP and assert RVALID in the next cycle, a latency of 1 cycle.
REQ-013 SHALL hold RDATA, RRESP and RVALID stable in R_DATA until RREADY is sampled high, then return to R_IDLE.
REQ-014 SHALL run the read and write FSMs independently.
REQ-015 When a read and a write target the same register in the same cycle, RDATA SHALL return the value before the write.
REQ-016 A write with WSTRB=0000 SHALL complete with OKAY and SHALL leave the register unchanged.
REQ-017 REG_OUT SHALL reflect a committed write in the cycle after the commit edge.

Reset
REQ-018 When ARESET is high at a clock edge, both FSMs SHALL return to their idle states and all registers SHALL be cleared to 0.
REQ-019 Reset output values SHALL be: AWREADY, WREADY and ARREADY at 0 during reset and 1 in the first cycle after reset; BVALID=0; RVALID=0; BRESP=00; RRESP=00; RDATA=0.
REQ-020 Reset mid-transaction SHALL drop any latched address, data or response with no register update.

Configuration
REQ-021 With macro AXI_SLVERR_EN defined, an access whose index is >= C_NUM_REGS SHALL return SLVERR (10), a write SHALL modify nothing, and a read SHALL return RDATA=0.
REQ-022 Without AXI_SLVERR_EN, such an access SHALL return OKAY (00), a write SHALL be discarded, and a read SHALL return RDATA=0.

Verification
REQ-023 Write 0x1, 0x2, 0x3 and 0x4 to addresses 0x0, 0x4, 0x8 and 0xC, then read each back -> every BRESP=00 and RDATA equals 0x1, 0x2, 0x3 and 0x4 respectively.
REQ-024 Present W three cycles before AW with data 0xDEADBEEF at address 0x4 -> exactly one BVALID pulse and REG_OUT[63:32]=0xDEADBEEF.
REQ-025 Write 0xAABBCCDD with WSTRB=0101 to address 0x0, which holds 0x11223344 -> register reads 0x11BB33DD.
REQ-026 Hold BREADY and RREADY low for 5 cycles -> BVALID, RVALID, RDATA and the ready signals stay stable with no second acceptance.
REQ-027 Write then read address 0x10 with C_NUM_REGS=4 -> BRESP and RRESP are 10 with the macro and 00 without it; RDATA=0 in both builds.
REQ-028 Assert ARESET for one cycle while in W_WAIT after address 0x8 is latched -> BVALID never asserts, all registers are 0 and the next full write succeeds.
